// File: rtl/spi_wdg_pkg.sv
// Shared types and constants for the SPI watchdog supervisor.
// Optional statistics counter is enabled by defining SPI_WDG_STATS_EN.
package spi_wdg_pkg;

  typedef enum logic [1:0] {IDLE, WATCH, ABORT, FAULT} wdg_sup_state_t;

  // A watchdog write of zero stops the watchdog counter.
  localparam int WDG_DISARM = 0;

  localparam int STATS_W = 16;

  function automatic logic [STATS_W-1:0] stats_sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_wdg_if.sv
// Supervisor <-> watchdog link. we is a one-cycle write strobe qualifying cycles
// (no ready: the watchdog accepts every write); inter is a one-cycle timeout pulse.
interface spi_wdg_if #(parameter int N = 12) ();
  logic [N-1:0] cycles;
  logic         we;
  logic         inter;

  modport master (output cycles, output we, input inter);
  modport slave  (input cycles, input we, output inter);
endinterface

// File: rtl/spi_pulse_stretch.sv
// Turns a start pulse into an abort level held ABORT_CYC cycles; o_done marks
// the final high cycle so the caller can leave on the same edge the level drops.
module spi_pulse_stretch #(
  parameter int ABORT_CYC = 4
) (
  input  logic i_clk_p,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_abort,
  output logic o_done
);

  localparam int CW = (ABORT_CYC > 1) ? $clog2(ABORT_CYC) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_abort;

  always_ff @(posedge i_clk_p or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else if (i_start) begin
      r_cnt   <= CW'(ABORT_CYC - 1);
      r_abort <= 1'b1;
    end else if (r_abort) begin
      if (r_cnt == '0) r_abort <= 1'b0;
      else             r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign o_abort = r_abort;
  assign o_done  = r_abort && (r_cnt == '0);

endmodule

// File: rtl/spi_wdg_supervisor.sv
// Arms/kicks/disarms the SPI watchdog around transactions, aborts on timeout and
// latches a fault after MAX_RETRY consecutive timeouts. SPI_WDG_STATS_EN adds o_timeout_total.
module spi_wdg_supervisor
  import spi_wdg_pkg::*;
#(
  parameter int N         = 12,
  parameter int RETRY_W   = 3,
  parameter int MAX_RETRY = 3,
  parameter int ABORT_CYC = 4
) (
  input  logic                 i_clk_p,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_timeout,
  input  logic                 i_cfg_we,
  input  logic                 i_enable,
  input  logic                 i_busy,
  input  logic                 i_activity,
  input  logic                 i_fault_clr,
  spi_wdg_if.master            wdg,
  output logic                 o_abort,
  output logic                 o_fault,
  output logic [RETRY_W-1:0]   o_retry_cnt,
`ifdef SPI_WDG_STATS_EN
  output logic [STATS_W-1:0]   o_timeout_total,
`endif
  output wdg_sup_state_t       o_state
);

  wdg_sup_state_t     r_state;
  logic [N-1:0]       r_cfg;
  logic [N-1:0]       r_cycles;
  logic               r_we;
  logic [RETRY_W-1:0] r_retry;
  logic               r_fault;
  logic               w_timeout;
  logic               w_abort_done;

  // A timeout only counts while watching and no higher-priority exit applies.
  assign w_timeout = (r_state == WATCH) && i_enable && i_busy && wdg.inter;

  spi_pulse_stretch #(.ABORT_CYC(ABORT_CYC)) u_stretch (
    .i_clk_p (i_clk_p),
    .i_rst_n (i_rst_n),
    .i_start (w_timeout),
    .o_abort (o_abort),
    .o_done  (w_abort_done)
  );

  always_ff @(posedge i_clk_p or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cfg    <= '0;
      r_cycles <= '0;
      r_we     <= 1'b0;
      r_retry  <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (i_cfg_we) r_cfg <= i_timeout;
      case (r_state)
        IDLE: begin
          if (i_enable && i_busy && (r_cfg != '0)) begin
            r_we     <= 1'b1;
            r_cycles <= r_cfg;
            r_state  <= WATCH;
          end
        end
        WATCH: begin
          if (!i_enable) begin
            r_we     <= 1'b1;
            r_cycles <= N'(WDG_DISARM);
            r_state  <= IDLE;
          end else if (!i_busy) begin
            r_we     <= 1'b1;
            r_cycles <= N'(WDG_DISARM);
            r_retry  <= '0;
            r_state  <= IDLE;
          end else if (wdg.inter) begin
            r_we     <= 1'b1;
            r_cycles <= N'(WDG_DISARM);
            r_retry  <= (r_retry == RETRY_W'(MAX_RETRY)) ? r_retry : r_retry + 1'b1;
            r_state  <= ABORT;
          end else if (i_cfg_we) begin
            // New timeout takes effect immediately; zero doubles as a disarm.
            r_we     <= 1'b1;
            r_cycles <= i_timeout;
            if (i_timeout == '0) r_state <= IDLE;
          end else if (i_activity) begin
            r_we     <= 1'b1;
            r_cycles <= r_cfg;
          end
        end
        ABORT: begin
          if (w_abort_done) begin
            if (r_retry == RETRY_W'(MAX_RETRY)) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        FAULT: begin
          if (i_fault_clr) begin
            r_state <= IDLE;
            r_fault <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Clearing the retry count overrides any same-cycle update above.
      if (i_fault_clr) r_retry <= '0;
    end
  end

`ifdef SPI_WDG_STATS_EN
  logic [STATS_W-1:0] r_total;

  always_ff @(posedge i_clk_p or negedge i_rst_n) begin
    if (!i_rst_n)         r_total <= '0;
    else if (i_fault_clr) r_total <= '0;
    else if (w_timeout)   r_total <= stats_sat_inc(r_total);
  end

  assign o_timeout_total = r_total;
`endif

  assign wdg.cycles  = r_cycles;
  assign wdg.we      = r_we;
  assign o_fault     = r_fault;
  assign o_retry_cnt = r_retry;
  assign o_state     = r_state;

endmodule

// File: tb/tb_spi_wdg_supervisor.sv
// Supervisor bench with a behavioural watchdog, a reference model fed each cycle
// and a monitor that pops expected outputs and watchdog writes from queues.
module tb_spi_wdg_supervisor;
  import spi_wdg_pkg::*;

  localparam int N    = 12;
  localparam int RW   = 3;
  localparam int MAXR = 3;
  localparam int ACYC = 4;
  localparam int W    = 34;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   timeout = '0;
  logic           cfg_we = 1'b0, enable = 1'b0, busy = 1'b0, activity = 1'b0, fault_clr = 1'b0;
  logic           abort, fault;
  logic [RW-1:0]  retry;
  wdg_sup_state_t state;
`ifdef SPI_WDG_STATS_EN
  logic [15:0]    ttotal;
`endif

  spi_wdg_if #(.N(N)) wif ();

  spi_wdg_supervisor #(.N(N), .RETRY_W(RW), .MAX_RETRY(MAXR), .ABORT_CYC(ACYC)) dut (
    .i_clk_p         (clk),
    .i_rst_n         (rst_n),
    .i_timeout       (timeout),
    .i_cfg_we        (cfg_we),
    .i_enable        (enable),
    .i_busy          (busy),
    .i_activity      (activity),
    .i_fault_clr     (fault_clr),
    .wdg             (wif),
    .o_abort         (abort),
    .o_fault         (fault),
    .o_retry_cnt     (retry),
`ifdef SPI_WDG_STATS_EN
    .o_timeout_total (ttotal),
`endif
    .o_state         (state)
  );

  // behavioural watchdog: a write loads count and reload; nonzero reload counts down,
  // pulses inter on reaching zero and reloads itself
  logic [N-1:0] wd_cnt, wd_reload;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0; wd_reload <= '0; wif.inter <= 1'b0;
    end else begin
      wif.inter <= 1'b0;
      if (wif.we) begin
        wd_cnt <= wif.cycles; wd_reload <= wif.cycles;
      end else if (wd_reload != '0) begin
        if (wd_cnt == '0) begin
          wif.inter <= 1'b1; wd_cnt <= wd_reload;
        end else begin
          wd_cnt <= wd_cnt - 1'b1;
        end
      end
    end
  end

  // scoreboard
  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] wr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    total_cnt++;
    bad_cnt++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  function automatic logic [W-1:0] dut_vec();
    logic [15:0] st;
    st = '0;
`ifdef SPI_WDG_STATS_EN
    st = ttotal;
`endif
    return {st, wif.cycles, wif.we, abort, fault, retry};
  endfunction

  // reference model: phase name, remaining abort cycles, plain integer counters
  string ph;
  int    ab_left, m_retry, m_cfg, m_cyc, m_total;
  bit    m_we, m_fault;

  function automatic logic [W-1:0] model_vec();
    logic [15:0] st;
    st = '0;
`ifdef SPI_WDG_STATS_EN
    st = 16'(m_total);
`endif
    return {st, N'(m_cyc), m_we, (ph == "abort"), m_fault, RW'(m_retry)};
  endfunction

  task automatic model_reset();
    ph = "idle"; ab_left = 0; m_retry = 0; m_cfg = 0; m_cyc = 0; m_total = 0;
    m_we = 0; m_fault = 0;
    exp_q.delete(); wr_q.delete();
  endtask

  task automatic wd_write(input int v);
    m_we = 1; m_cyc = v;
    wr_q.push_back(N'(v));
  endtask

  task automatic model_cycle();
    int nxt_cfg;
    bit evt;
    nxt_cfg = cfg_we ? int'(timeout) : m_cfg;
    evt = 0;
    m_we = 0;
    case (ph)
      "idle": if (enable && busy && m_cfg != 0) begin wd_write(m_cfg); ph = "watch"; end
      "watch": begin
        if (!enable) begin wd_write(0); ph = "idle"; end
        else if (!busy) begin wd_write(0); m_retry = 0; ph = "idle"; end
        else if (wif.inter) begin
          wd_write(0); evt = 1; ab_left = ACYC; ph = "abort";
          if (m_retry < MAXR) m_retry++;
        end
        else if (cfg_we) begin wd_write(int'(timeout)); if (timeout == '0) ph = "idle"; end
        else if (activity) wd_write(m_cfg);
      end
      "abort": begin
        ab_left--;
        if (ab_left == 0) begin
          if (m_retry == MAXR) begin ph = "fault"; m_fault = 1; end
          else ph = "idle";
        end
      end
      "fault": if (fault_clr) begin ph = "idle"; m_fault = 0; end
      default: ;
    endcase
    if (fault_clr) begin m_retry = 0; m_total = 0; end
    else if (evt && m_total < 65535) m_total++;
    m_cfg = nxt_cfg;
    exp_q.push_back(model_vec());
  endtask

  // driver tasks: inputs change on the falling edge, model predicts the next rising edge
  task automatic drive(input bit en, input bit bs, input bit act, input bit cwe,
                       input int tmo, input bit fclr);
    enable = en; busy = bs; activity = act; cfg_we = cwe; timeout = N'(tmo); fault_clr = fclr;
    model_cycle();
  endtask

  task automatic step(input bit en, input bit bs, input bit act, input bit cwe,
                      input int tmo, input bit fclr);
    @(negedge clk);
    drive(en, bs, act, cwe, tmo, fclr);
  endtask

  task automatic steps(input int n, input bit bs);
    for (int i = 0; i < n; i++) step(1, bs, 0, 0, 10, 0);
  endtask

  // returns at a falling edge where inter is pending; caller must drive right away
  task automatic wait_inter(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wif.inter && ph == "watch") return;
      drive(1, 1, 0, 0, 10, 0);
    end
    bound_fail(name);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 0; busy = 0; activity = 0; cfg_we = 0; timeout = '0; fault_clr = 0;
    model_reset();
    #1;
    check("reset_async", 64'(dut_vec()), 64'(0));
    @(posedge clk); #1;
    check("reset_edge", 64'(dut_vec()), 64'(0));
    check("reset_state", 64'(state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", 64'(dut_vec()), 64'(e));
      end
      if (rst_n && wif.we) begin
        if (wr_q.size() == 0) begin
          total_cnt++; bad_cnt++;
          $display("FAIL wdg_write actual=%h required=none t=%0t", wif.cycles, $time);
        end else begin
          check("wdg_write", 64'(wif.cycles), 64'(wr_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  // stimulus
  initial begin
    bit bs;
    int bs_left;
    model_reset();
    do_reset();
    step(0, 0, 0, 1, 10, 0);

    // kicked transaction ends cleanly
    for (int i = 0; i < 60; i++) step(1, 1, (i % 5 == 4), 0, 10, 0);
    steps(5, 0);
    check("t1_retry", 64'(retry), 64'(0));

    // unkicked transaction times out, aborts, re-arms
    wait_inter("t2_inter");
    drive(1, 1, 0, 0, 10, 0);
    steps(6, 1);
    check("t2_retry", 64'(retry), 64'(1));
    check("t2_rearm", 64'(state), 64'(WATCH));

    // keep failing until the fault latches, then clear it
    for (int i = 0; i < 200 && ph != "fault"; i++) step(1, 1, 0, 0, 10, 0);
    steps(30, 1);
    check("t3_fault", 64'(fault), 64'(1));
    check("t3_retry", 64'(retry), 64'(MAXR));
    check("t3_state", 64'(state), 64'(FAULT));
    step(1, 1, 0, 0, 10, 1);
    steps(2, 1);
    check("t3_clr_fault", 64'(fault), 64'(0));
    check("t3_clr_retry", 64'(retry), 64'(0));
    check("t3_clr_rearm", 64'(state), 64'(WATCH));
    steps(3, 0);

    // busy falling with inter is a success; activity with inter is still a timeout
    wait_inter("t4_inter_busy");
    drive(1, 0, 0, 0, 10, 0);
    steps(6, 0);
    check("t4_success_retry", 64'(retry), 64'(0));
    check("t4_success_abort", 64'(abort), 64'(0));
    wait_inter("t4_inter_act");
    drive(1, 1, 1, 0, 10, 0);
    steps(6, 1);
    check("t4_act_retry", 64'(retry), 64'(1));
    steps(3, 0);

    // zero timeout written while watching disarms
    steps(4, 1);
    step(1, 1, 0, 1, 0, 0);
    steps(3, 1);
    check("t5_disarm_state", 64'(state), 64'(IDLE));
    check("t5_disarm_abort", 64'(abort), 64'(0));
    step(1, 1, 0, 1, 10, 0);
    wait_inter("t5_inter");
    drive(1, 1, 0, 0, 10, 0);
    steps(2, 1);
    check("t5_abort_live", 64'(abort), 64'(1));
    do_reset();
    step(0, 0, 0, 1, 10, 0);

    // randomized traffic
    bs = 0; bs_left = 0;
    for (int i = 0; i < 1500; i++) begin
      int tmo;
      if (bs_left == 0) begin bs = ~bs; bs_left = $urandom_range(3, 40); end
      bs_left--;
      tmo = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 15);
      step($urandom_range(0, 15) != 0, bs, $urandom_range(0, 7) == 0,
           $urandom_range(0, 29) == 0, tmo, $urandom_range(0, 39) == 0);
    end
    step(1, 0, 0, 0, 10, 1);
    steps(8, 0);

`ifdef SPI_WDG_STATS_EN
    // five timeouts spread over runs separated by successes
    do_reset();
    step(0, 0, 0, 1, 10, 0);
    for (int k = 0; k < 5; k++) begin
      wait_inter("t6_inter");
      drive(1, 1, 0, 0, 10, 0);
      steps(5, 1);
      if (k == 1 || k == 3) steps(3, 0);
    end
    steps(8, 0);
    check("t6_total", 64'(ttotal), 64'(5));
    step(1, 0, 0, 0, 10, 1);
    steps(1, 0);
    check("t6_total_clr", 64'(ttotal), 64'(0));
`endif

    @(posedge clk); #2;
    @(posedge clk); #2;
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("wr_q_drained", 64'(wr_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
